ex_wb_stage: RTL and testbench
==============================

Name: ex_wb_stage

Overview:
- Execute-to-writeback pipeline stage directly downstream of the n-bit ALU slice chain.
- Captures ALU result and raw flags, applies the 3-bit scale code (arithmetic shift), and registers the scaled result.
- Presents the registered result to the register-file write port through a valid/ready handshake, with a forwarding tap for the operand stage.
- Owns the architectural NZCV flag register and a retired-instruction counter.

Parameters:
- N, 32, datapath width; matches ALU width.
- A, 5, register-file address width.
- ZERO_REG, 1, when 1, writes to address 0 are suppressed: entry retires, wb_we low.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- alu_f  in  N  ALU Fout, two's complement.
- alu_v  in  1  ALU overflow.
- alu_cout  in  1  ALU carry out.
- scale_c  in  3  shift code: 0 >>>3, 1 >>>2, 2 >>>1, 3 pass, 4 <<<1, 5 <<<2, 6 <<<3, 7 zero.
- dst_addr  in  A  destination register.
- wr_en  in  1  instruction writes a register.
- flag_we  in  1  instruction updates NZCV.
- flush  in  1  synchronous kill of the held entry and any incoming entry.
- wb_valid  out  1  held entry valid.
- wb_ready  in  1  register-file port accepts.
- wb_we  out  1  register write strobe.
- wb_addr  out  A  write address.
- wb_data  out  N  scaled result.
- fwd_valid  out  1  forwarding match enable.
- fwd_addr  out  A  forwarding address.
- fwd_data  out  N  forwarding data.
- flags  out  4  architectural {N,Z,C,V}.
- retired  out  32  retired-entry count.

Behaviour:
- Reset (async, rst_n low): wb_valid=0, wb_addr=0, wb_data=0, flags=4'b0000, retired=0, fwd_valid=0. in_ready=1 once reset is released.
- Handshake:
  - in_ready = !wb_valid || wb_ready (combinational; no dependency on in_valid).
  - Capture occurs when in_valid && in_ready && !flush.
  - Retire occurs when wb_valid && wb_ready && !flush.
  - Capture and retire in the same cycle is legal: the new entry replaces the old one with no bubble.
- Latency: 1 cycle from capture to wb_valid. Throughput is 1 per cycle while wb_ready is held high.
- Scaling, combinational, before the register:
  - Right shifts are arithmetic (sign-filling). Left shifts fill with zeros.
  - Code 7 gives a result of 0.
- Shift overflow sv:
  - Left shift by k (1..3): sv=1 when bits alu_f[N-1:N-1-k] are not all equal.
  - All other codes: sv=0.
- Stored flags with each entry:
  - N = scaled[N-1].
  - Z = (scaled == 0).
  - C = alu_cout, unaffected by scaling.
  - V = alu_v | sv.
- Outputs:
  - wb_we = wb_valid && wr_en_q && !(ZERO_REG && wb_addr==0).
  - fwd_valid = wb_we (no dependency on wb_ready). fwd_addr = wb_addr, fwd_data = wb_data.
- Flag register: updates on retire only when flag_we_q=1, otherwise holds. A flush never changes the flag register.
- retired: increments by 1 on each retire, including entries with wr_en=0 and entries suppressed by ZERO_REG. Wraps from 0xFFFFFFFF to 0.
- Flush:
  - wb_valid clears next cycle; no retire and no flag update that cycle.
  - A simultaneous in_valid is dropped.
  - Flush has priority over capture and over retire.
- Stall: while wb_valid && !wb_ready, all registered fields hold exactly and in_ready=0.
- Reset asserted mid-operation: the entry is lost; no retire or flag update is produced.

Decomposition:
- Shared package holds:
  - scale code constants SC_SRA3..SC_ZERO (0..7);
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, ex_scale_unit: input alu_f and scale_c; outputs scaled and sv. Reused by any future shift-capable stage.
- Pipeline register, flag register and counter stay in ex_wb_stage.

Test Plan:
- Reset then a single entry (N=32): alu_f=0x0000_0010, scale_c=2, dst=3, wr_en=1, flag_we=1, wb_ready=1 -> next cycle wb_we=1, wb_addr=3, wb_data=0x0000_0008. Following cycle flags=4'b0000, retired=1.
- Negative right shift: alu_f=0xFFFF_FFF0, scale_c=0 -> wb_data=0xFFFF_FFFE, N=1, Z=0.
- Left-shift overflow: alu_f=0x4000_0000, scale_c=4, alu_v=0 -> wb_data=0x8000_0000, flags V=1, N=1. Also scale_c=7 with any alu_f -> wb_data=0, Z=1.
- Backpressure: hold wb_ready=0 for 3 cycles with in_valid=1 -> in_ready=0; wb_data, wb_addr and flags unchanged. Then wb_ready=1 for 4 back-to-back entries -> 4 retires in 4 cycles and retired advances by 4.
- Zero register and flush:
  - dst=0, wr_en=1 -> wb_we=0, retired still increments.
  - flush asserted with wb_valid=1 and in_valid=1 -> wb_valid=0 next cycle, flags and retired unchanged.
- Counter wrap: force retired to 0xFFFF_FFFF, retire one entry -> retired=0. Then assert rst_n=0 asynchronously mid-stall -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/ex_wb_stage_pkg.sv
// Shared types and constants for the execute-to-writeback stage:
// scale codes, NZCV flag layout and the flag-building helper.
package ex_wb_stage_pkg;

    localparam int unsigned SC_W   = 3;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CNT_W  = 32;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [SC_W-1:0] {
        SC_SRA3 = 3'd0,
        SC_SRA2 = 3'd1,
        SC_SRA1 = 3'd2,
        SC_PASS = 3'd3,
        SC_SHL1 = 3'd4,
        SC_SHL2 = 3'd5,
        SC_SHL3 = 3'd6,
        SC_ZERO = 3'd7
    } scale_code_t;

    // Field order matches FLAG_N..FLAG_V so the struct casts straight to a 4-bit vector.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    function automatic nzcv_t make_flags(input logic msb, input logic is_zero,
                                         input logic cout, input logic ovf);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_N] = msb;
        f[FLAG_Z] = is_zero;
        f[FLAG_C] = cout;
        f[FLAG_V] = ovf;
        return nzcv_t'(f);
    endfunction

endpackage

// File: rtl/ex_wb_stage_if.sv
// Upstream entry bus, register-file write port and forwarding tap of the
// execute-to-writeback stage.
interface ex_wb_stage_if
    import ex_wb_stage_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned A = 5
);
    // Upstream (ALU side) entry
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    alu_f;
    logic            alu_v;
    logic            alu_cout;
    logic [SC_W-1:0] scale_c;
    logic [A-1:0]    dst_addr;
    logic            wr_en;
    logic            flag_we;

    // Register-file write port
    logic            wb_valid;
    logic            wb_ready;
    logic            wb_we;
    logic [A-1:0]    wb_addr;
    logic [N-1:0]    wb_data;

    // Forwarding tap towards the operand stage
    logic            fwd_valid;
    logic [A-1:0]    fwd_addr;
    logic [N-1:0]    fwd_data;

    modport master (
        output in_valid, alu_f, alu_v, alu_cout, scale_c, dst_addr, wr_en, flag_we,
        output wb_ready,
        input  in_ready,
        input  wb_valid, wb_we, wb_addr, wb_data,
        input  fwd_valid, fwd_addr, fwd_data
    );

    modport slave (
        input  in_valid, alu_f, alu_v, alu_cout, scale_c, dst_addr, wr_en, flag_we,
        input  wb_ready,
        output in_ready,
        output wb_valid, wb_we, wb_addr, wb_data,
        output fwd_valid, fwd_addr, fwd_data
    );

endinterface

// File: rtl/ex_wb_stage_scale.sv
// Combinational result scaler: arithmetic right shift, zero-fill left shift
// with signed-overflow detection, pass-through or forced zero.
module ex_scale_unit
    import ex_wb_stage_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]    alu_f,
    input  logic [SC_W-1:0] scale_c,
    output logic [N-1:0]    scaled,
    output logic            sv
);

    // Left shift by k overflows when the top k+1 bits are not a pure sign run.
    logic [3:0] top;
    assign top = alu_f[N-1 -: 4];

    always_comb begin
        scaled = alu_f;
        sv     = 1'b0;
        case (scale_code_t'(scale_c))
            SC_SRA3: scaled = N'($signed(alu_f) >>> 3);
            SC_SRA2: scaled = N'($signed(alu_f) >>> 2);
            SC_SRA1: scaled = N'($signed(alu_f) >>> 1);
            SC_PASS: scaled = alu_f;
            SC_SHL1: begin
                scaled = alu_f << 1;
                sv     = top[3] ^ top[2];
            end
            SC_SHL2: begin
                scaled = alu_f << 2;
                sv     = (top[3:1] != 3'b000) && (top[3:1] != 3'b111);
            end
            SC_SHL3: begin
                scaled = alu_f << 3;
                sv     = (top != 4'b0000) && (top != 4'b1111);
            end
            SC_ZERO: scaled = '0;
            default: scaled = alu_f;
        endcase
    end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: scales the ALU result, holds one entry for the
// register-file port, and owns the NZCV flag register and retire counter.
module ex_wb_stage
    import ex_wb_stage_pkg::*;
#(
    parameter int unsigned N        = 32,
    parameter int unsigned A        = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_wb_stage_if.slave      bus,
    input  logic              flush,
    output logic [FLAG_W-1:0] flags,
    output logic [CNT_W-1:0]  retired
);

    logic [N-1:0] scaled;
    logic         sv;
    nzcv_t        entry_flags_c;

    logic         in_ready_c;
    logic         capture;
    logic         retire;

    // Held entry
    logic         valid_q;
    logic         wr_en_q;
    logic         flag_we_q;
    logic [A-1:0] addr_q;
    logic [N-1:0] data_q;
    nzcv_t        eflags_q;

    // Architectural state
    nzcv_t        flags_q;
    logic [CNT_W-1:0] retired_q;

    logic         we_c;

    ex_scale_unit #(.N(N)) u_scale (
        .alu_f   (bus.alu_f),
        .scale_c (bus.scale_c),
        .scaled  (scaled),
        .sv      (sv)
    );

    assign entry_flags_c = make_flags(scaled[N-1], (scaled == '0), bus.alu_cout,
                                      bus.alu_v | sv);

    // Flush outranks both capture and retire.
    assign in_ready_c = !valid_q || bus.wb_ready;
    assign capture    = bus.in_valid && in_ready_c && !flush;
    assign retire     = valid_q && bus.wb_ready && !flush;

    // Pipeline register: capture may replace a retiring entry with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            flag_we_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            eflags_q  <= '0;
        end else if (flush) begin
            valid_q   <= 1'b0;
        end else if (capture) begin
            valid_q   <= 1'b1;
            wr_en_q   <= bus.wr_en;
            flag_we_q <= bus.flag_we;
            addr_q    <= bus.dst_addr;
            data_q    <= scaled;
            eflags_q  <= entry_flags_c;
        end else if (retire) begin
            valid_q   <= 1'b0;
        end
    end

    // Flag register and retire counter advance only on a real retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= '0;
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
            if (flag_we_q) begin
                flags_q <= eflags_q;
            end
        end
    end

    assign we_c = valid_q && wr_en_q && !(ZERO_REG && (addr_q == '0));

    assign bus.in_ready  = in_ready_c;
    assign bus.wb_valid  = valid_q;
    assign bus.wb_we     = we_c;
    assign bus.wb_addr   = addr_q;
    assign bus.wb_data   = data_q;
    assign bus.fwd_valid = we_c;
    assign bus.fwd_addr  = addr_q;
    assign bus.fwd_data  = data_q;

    assign flags   = flags_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Randomized and directed checks of ex_wb_stage against a transaction-level model.
module tb_ex_wb_stage;
    import ex_wb_stage_pkg::*;

    localparam int unsigned N = 32;
    localparam int unsigned A = 5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  flags;
    logic [31:0] retired;

    ex_wb_stage_if #(.N(N), .A(A)) bus ();

    ex_wb_stage #(.N(N), .A(A), .ZERO_REG(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .flush   (flush),
        .flags   (flags),
        .retired (retired)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the held entry and architectural state
    bit        m_valid;
    bit        m_wr;
    bit        m_fwe;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    bit [3:0]  m_eflags;
    bit [3:0]  m_flags;
    bit [31:0] m_retired;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scaling as signed arithmetic: floor division by 2^k, or multiplication by 2^k
    // with overflow meaning the product leaves the 32-bit signed range.
    function automatic void ref_scale(input logic [31:0] f, input logic [2:0] sc,
                                      output logic [31:0] r, output bit ov);
        longint s;
        longint d;
        longint q;
        s  = longint'($signed(f));
        ov = 1'b0;
        r  = f;
        if (sc <= 3'd2) begin
            d = longint'(1) << (3 - int'(sc));
            q = s / d;
            if ((s % d != 0) && (s < 0)) q = q - 1;
            r = q[31:0];
        end else if (sc == 3'd3) begin
            r = f;
        end else if (sc <= 3'd6) begin
            q  = s * (longint'(1) << (int'(sc) - 3));
            ov = (q > 64'sd2147483647) || (q < -64'sd2147483648);
            r  = q[31:0];
        end else begin
            r = 32'd0;
        end
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wr = 0; m_fwe = 0; m_addr = '0; m_data = '0;
        m_eflags = '0; m_flags = '0; m_retired = '0;
    endtask

    task automatic model_step();
        bit          rdy;
        bit          cap;
        bit          ret;
        logic [31:0] r;
        bit          ov;
        rdy = !m_valid || bus.wb_ready;
        cap = bus.in_valid && rdy && !flush;
        ret = m_valid && bus.wb_ready && !flush;
        if (ret) begin
            m_retired++;
            if (m_fwe) m_flags = m_eflags;
        end
        if (flush) begin
            m_valid = 0;
        end else if (cap) begin
            ref_scale(bus.alu_f, bus.scale_c, r, ov);
            m_valid  = 1;
            m_data   = r;
            m_addr   = bus.dst_addr;
            m_wr     = bus.wr_en;
            m_fwe    = bus.flag_we;
            m_eflags = {r[31], (r == 32'd0), bus.alu_cout, bus.alu_v | ov};
        end else if (ret) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs();
        bit exp_we;
        exp_we = m_valid && m_wr && (m_addr != 5'd0);
        check("wb_valid",  64'(bus.wb_valid),  64'(m_valid));
        check("wb_we",     64'(bus.wb_we),     64'(exp_we));
        check("wb_addr",   64'(bus.wb_addr),   64'(m_addr));
        check("wb_data",   64'(bus.wb_data),   64'(m_data));
        check("fwd_valid", 64'(bus.fwd_valid), 64'(exp_we));
        check("fwd_addr",  64'(bus.fwd_addr),  64'(m_addr));
        check("fwd_data",  64'(bus.fwd_data),  64'(m_data));
        check("flags",     64'(flags),         64'(m_flags));
        check("retired",   64'(retired),       64'(m_retired));
    endtask

    task automatic drive(input bit iv, input logic [31:0] f, input bit v, input bit co,
                         input logic [2:0] sc, input logic [4:0] dst, input bit we,
                         input bit fwe, input bit rdy, input bit fl);
        bus.in_valid = iv;
        bus.alu_f    = f;
        bus.alu_v    = v;
        bus.alu_cout = co;
        bus.scale_c  = sc;
        bus.dst_addr = dst;
        bus.wr_en    = we;
        bus.flag_we  = fwe;
        bus.wb_ready = rdy;
        flush        = fl;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd3, 5'd0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    // One clock: check the combinational ready, advance model and DUT, check state.
    task automatic cycle();
        bit exp_rdy;
        #1;
        exp_rdy = !m_valid || bus.wb_ready;
        check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wb_valid"},  64'(bus.wb_valid),  64'(0));
        check({tag, "_wb_addr"},   64'(bus.wb_addr),   64'(0));
        check({tag, "_wb_data"},   64'(bus.wb_data),   64'(0));
        check({tag, "_fwd_valid"}, 64'(bus.fwd_valid), 64'(0));
        check({tag, "_flags"},     64'(flags),         64'(0));
        check({tag, "_retired"},   64'(retired),       64'(0));
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'(1));
    endtask

    initial begin
        model_reset();
        idle(1'b1);
        rst_n = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single entry: 0x10 >>> 1 to r3
        drive(1, 32'h0000_0010, 0, 0, 3'd2, 5'd3, 1, 1, 1, 0);
        cycle();
        check("single_we",   64'(bus.wb_we),   64'(1));
        check("single_addr", 64'(bus.wb_addr), 64'(3));
        check("single_data", 64'(bus.wb_data), 64'h8);
        idle(1'b1);
        cycle();
        check("single_flags",   64'(flags),   64'(4'b0000));
        check("single_retired", 64'(retired), 64'(1));

        // Negative arithmetic right shift
        drive(1, 32'hFFFF_FFF0, 0, 0, 3'd0, 5'd5, 1, 1, 1, 0);
        cycle();
        check("neg_data", 64'(bus.wb_data), 64'hFFFF_FFFE);
        idle(1'b1);
        cycle();
        check("neg_flags", 64'(flags), 64'(4'b1000));

        // Left-shift overflow
        drive(1, 32'h4000_0000, 0, 0, 3'd4, 5'd6, 1, 1, 1, 0);
        cycle();
        check("ovf_data", 64'(bus.wb_data), 64'h8000_0000);
        idle(1'b1);
        cycle();
        check("ovf_flags", 64'(flags), 64'(4'b1001));

        // Scale code 7 forces zero
        drive(1, $urandom, 0, 1, 3'd7, 5'd7, 1, 1, 1, 0);
        cycle();
        check("zero_data", 64'(bus.wb_data), 64'(0));
        idle(1'b1);
        cycle();
        check("zero_flags", 64'(flags), 64'(4'b0110));

        // Backpressure: held entry must not move while wb_ready is low
        drive(1, 32'h0000_0123, 0, 0, 3'd3, 5'd9, 1, 1, 1, 0);
        cycle();
        drive(1, 32'h0000_0999, 0, 0, 3'd3, 5'd10, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_in_ready", 64'(bus.in_ready), 64'(0));
            check("stall_data",     64'(bus.wb_data),  64'h123);
            check("stall_addr",     64'(bus.wb_addr),  64'(9));
            check("stall_flags",    64'(flags),        64'(4'b0110));
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i + 1), 0, 0, 3'd3, 5'(i + 11), 1, 1, 1, 0);
            cycle();
        end
        check("b2b_retired", 64'(retired), 64'(8));
        idle(1'b1);
        cycle();
        check("b2b_drain_retired", 64'(retired), 64'(9));

        // Writes to r0 are suppressed but still retire
        drive(1, 32'h0000_0005, 0, 0, 3'd3, 5'd0, 1, 1, 1, 0);
        cycle();
        check("zreg_we",  64'(bus.wb_we),     64'(0));
        check("zreg_fwd", 64'(bus.fwd_valid), 64'(0));
        idle(1'b1);
        cycle();
        check("zreg_retired", 64'(retired), 64'(10));

        // Flush kills held and incoming entries without touching flags or counter
        drive(1, 32'h8000_0000, 0, 0, 3'd3, 5'd12, 1, 1, 0, 0);
        cycle();
        drive(1, 32'h8000_0000, 1, 1, 3'd3, 5'd13, 1, 1, 1, 1);
        cycle();
        check("flush_valid",   64'(bus.wb_valid), 64'(0));
        check("flush_flags",   64'(flags),        64'(4'b0000));
        check("flush_retired", 64'(retired),      64'(10));
        idle(1'b1);
        cycle();
        check("flush_after_retired", 64'(retired), 64'(10));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] sc;
            logic [4:0] dst;
            sc  = 3'($urandom_range(0, 7));
            dst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            drive(($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 1'($urandom), sc, dst,
                  1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0));
            cycle();
        end

        // Counter wrap
        drive(1, 32'h0000_0042, 0, 0, 3'd3, 5'd1, 1, 0, 0, 0);
        cycle();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        m_retired = 32'hFFFF_FFFF;
        check("wrap_preload", 64'(retired), 64'hFFFF_FFFF);
        idle(1'b1);
        cycle();
        check("wrap_retired", 64'(retired), 64'(0));

        // Asynchronous reset while stalled
        drive(1, 32'h0000_1234, 0, 1, 3'd3, 5'd4, 1, 1, 1, 0);
        cycle();
        drive(1, 32'h0000_5678, 0, 1, 3'd3, 5'd8, 1, 1, 0, 0);
        cycle();
        check("pre_reset_valid", 64'(bus.wb_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
